// File: rtl/multi_input_sum_using_fifos_and_double_buffer.sv
// N-channel streaming adder. Each channel has a first-word-fall-through FIFO.
// When every channel has a word, one word is popped from each channel and the
// words are summed. The sum is registered into a 2-slot output buffer whose
// upstream ready is itself a register, so no output depends combinationally
// on sum_ready or in_*.

// Per-channel first-word-fall-through FIFO; push/pop are pre-qualified by the caller
module mis_fifo #(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q;

    assign full  = (cnt_q == CW'(depth));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rp_q];

    // Storage array; contents need no reset since cnt_q gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wdata;
    end

    // Pointer and occupancy update; simultaneous push+pop keeps occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= (wp_q == AW'(depth - 1)) ? '0 : wp_q + AW'(1);
            if (pop)  rp_q <= (rp_q == AW'(depth - 1)) ? '0 : rp_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module multi_input_sum_using_fifos_and_double_buffer #(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int n_inputs = 4,
    parameter bit saturate = 1'b0,
    localparam int sum_width = width + $clog2(n_inputs)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [sum_width-1:0]      sum_data,
    output logic                      sum_overflow
);
    logic [n_inputs-1:0]            full, empty, push;
    logic [n_inputs-1:0][width-1:0] head;
    logic                           join_valid, pop, xfer;
    logic [sum_width-1:0]           raw, res;
    logic                           ovf;

    // Double-buffer state: slot 0 drives the outputs, slot 1 is the skid slot
    logic [1:0]           cnt_q, cnt_d;
    logic                 buf_up_ready_q, buf_up_ready_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [sum_width-1:0] sum_data_q, sum_data_d, skid_data_q, skid_data_d;
    logic                 sum_ovf_q, sum_ovf_d, skid_ovf_q, skid_ovf_d;

    for (genvar i = 0; i < n_inputs; i++) begin : g_ch
        assign in_ready[i] = ~full[i] & ~rst;
        assign push[i]     = in_valid[i] & in_ready[i];
        mis_fifo #(.width(width), .depth(depth)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop),
            .wdata (in_data[i*width +: width]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // All channels pop together, only when each has a word and the buffer has room
    assign join_valid = &(~empty);
    assign pop        = join_valid & buf_up_ready_q;
    assign xfer       = sum_valid_q & sum_ready;

    // Full-precision sum of the FIFO heads; sum_width guarantees no wrap
    always_comb begin
        raw = '0;
        for (int i = 0; i < n_inputs; i++) raw = raw + sum_width'(head[i]);
    end

    assign ovf = |raw[sum_width-1:width];
    assign res = (saturate && ovf) ? sum_width'({width{1'b1}}) : raw;

    // Next state of the 2-slot buffer from load (pop) and drain (xfer)
    always_comb begin
        sum_data_d  = sum_data_q;
        sum_ovf_d   = sum_ovf_q;
        skid_data_d = skid_data_q;
        skid_ovf_d  = skid_ovf_q;
        cnt_d       = cnt_q + 2'(pop) - 2'(xfer);
        case (cnt_q)
            2'd0: begin
                if (pop) begin
                    sum_data_d = res;
                    sum_ovf_d  = ovf;
                end
            end
            2'd1: begin
                if (pop && xfer) begin
                    sum_data_d = res;
                    sum_ovf_d  = ovf;
                end else if (xfer) begin
                    sum_data_d = '0;
                    sum_ovf_d  = 1'b0;
                end else if (pop) begin
                    skid_data_d = res;
                    skid_ovf_d  = ovf;
                end
            end
            default: begin
                // buf_up_ready_q is low here, so only a drain can occur
                if (xfer) begin
                    sum_data_d  = skid_data_q;
                    sum_ovf_d   = skid_ovf_q;
                    skid_data_d = '0;
                    skid_ovf_d  = 1'b0;
                end
            end
        endcase
        sum_valid_d    = (cnt_d != 2'd0);
        buf_up_ready_d = (cnt_d < 2'd2);
    end

    // Buffer registers; reset flushes both slots
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            buf_up_ready_q <= 1'b1;
            sum_valid_q    <= 1'b0;
            sum_data_q     <= '0;
            sum_ovf_q      <= 1'b0;
            skid_data_q    <= '0;
            skid_ovf_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            buf_up_ready_q <= buf_up_ready_d;
            sum_valid_q    <= sum_valid_d;
            sum_data_q     <= sum_data_d;
            sum_ovf_q      <= sum_ovf_d;
            skid_data_q    <= skid_data_d;
            skid_ovf_q     <= skid_ovf_d;
        end
    end

    assign sum_valid    = sum_valid_q;
    assign sum_data     = sum_data_q;
    assign sum_overflow = sum_ovf_q;
endmodule

// File: tb/tb_multi_input_sum_using_fifos_and_double_buffer.sv
// Bench: two instances (plain and saturating) share one stimulus stream.
// A monitor keeps per-channel queues of accepted words; the k-th output sum
// must equal the sum of the k-th word of every channel.
module tb_multi_input_sum_using_fifos_and_double_buffer;
    localparam int W  = 8;
    localparam int D  = 10;
    localparam int N  = 4;
    localparam int SW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           sum_ready;
    logic [N-1:0]   rdy0, rdy1;
    logic           sv0, sv1, so0, so1;
    logic [SW-1:0]  sd0, sd1;

    always #5 clk = ~clk;

    multi_input_sum_using_fifos_and_double_buffer #(
        .width(W), .depth(D), .n_inputs(N), .saturate(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .sum_valid(sv0), .sum_ready(sum_ready), .sum_data(sd0), .sum_overflow(so0)
    );

    multi_input_sum_using_fifos_and_double_buffer #(
        .width(W), .depth(D), .n_inputs(N), .saturate(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .sum_valid(sv1), .sum_ready(sum_ready), .sum_data(sd1), .sum_overflow(so1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int            q[N][$];
    int            n_out = 0;
    bit            stall_p = 0;
    logic [SW-1:0] stall_d;
    logic          stall_o;
    int            raw;
    bit            miss;

    // Monitor: record accepted words, check each transfer and stall stability
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            stall_p = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (in_valid[i] && rdy0[i]) q[i].push_back(int'(in_data[i*W +: W]));
            chk("ready_pair", rdy1, rdy0);
            if (stall_p) begin
                chk("stall_valid", sv0, 1);
                chk("stall_data", sd0, stall_d);
                chk("stall_ovf", so0, stall_o);
            end
            if (sv0 && sum_ready) begin
                miss = 0;
                for (int i = 0; i < N; i++) if (q[i].size() == 0) miss = 1;
                if (miss) begin
                    chk("extra_sum", 1, 0);
                end else begin
                    raw = 0;
                    for (int i = 0; i < N; i++) raw += q[i].pop_front();
                    chk("sum", sd0, raw);
                    chk("ovf", so0, (raw >= 256) ? 1 : 0);
                    chk("sat_valid", sv1, 1);
                    chk("sat_sum", sd1, (raw >= 256) ? 255 : raw);
                    chk("sat_ovf", so1, (raw >= 256) ? 1 : 0);
                end
                n_out++;
            end
            stall_p = sv0 && !sum_ready;
            stall_d = sd0;
            stall_o = so0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] v, input int d0, input int d1, input int d2, input int d3);
        in_valid = v;
        in_data  = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int acc[N];
    int sent[N];
    int base;
    int cyc;

    initial begin
        rst = 1; sum_ready = 0; in_valid = '0; in_data = '0;
        step(); step();
        chk("rst_inready", rdy0, 0);
        step();
        rst = 0;
        #1;
        chk("rst_valid", sv0, 0);
        chk("rst_data", sd0, 0);
        chk("rst_ovf", so0, 0);
        chk("post_rst_inready", rdy0, 4'hf);

        // Basic sum and 2-cycle latency
        sum_ready = 1;
        set_all(4'hf, 10, 20, 30, 40);
        step();
        in_valid = '0;
        chk("t1_early", sv0, 0);
        step();
        chk("t1_valid", sv0, 1);
        chk("t1_sum", sd0, 100);
        chk("t1_ovf", so0, 0);
        step(); step();

        // All-ones operands: full precision vs saturating
        set_all(4'hf, 255, 255, 255, 255);
        step();
        in_valid = '0;
        step();
        chk("t2_valid", sv0, 1);
        chk("t2_sum", sd0, 1020);
        chk("t2_ovf", so0, 1);
        chk("t2_sat_sum", sd1, 255);
        chk("t2_sat_ovf", so1, 1);
        step(); step();

        // Channels at different rates pair by arrival index
        for (int c = 1; c <= 3; c++) begin
            set_all(4'h1, c, 0, 0, 0);
            step();
        end
        in_valid = '0;
        step();
        chk("t3_idle1", sv0, 0);
        step();
        chk("t3_idle2", sv0, 0);
        for (int c = 0; c < 3; c++) begin
            set_all(4'he, 0, 0, 0, 0);
            step();
            if (c == 0) chk("t3_early", sv0, 0);
            if (c == 1) begin
                chk("t3_valid", sv0, 1);
                chk("t3_first", sd0, 1);
            end
        end
        in_valid = '0;
        for (int c = 0; c < 6; c++) step();

        // Backpressure: storage is depth+2 per channel
        sum_ready = 0;
        base = n_out;
        for (int i = 0; i < N; i++) acc[i] = 0;
        for (int c = 0; c < 20; c++) begin
            set_all(4'hf, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
            for (int i = 0; i < N; i++) acc[i] += int'(rdy0[i]);
            step();
        end
        for (int i = 0; i < N; i++) chk("bp_accepted", acc[i], D + 2);
        chk("bp_full", rdy0, 0);
        in_valid = '0;
        sum_ready = 1;
        step();
        chk("bp_ready_hold", rdy0, 0);
        step();
        chk("bp_ready_back", rdy0, 4'hf);
        cyc = 0;
        while (n_out - base < D + 2 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk("bp_drained", n_out - base, D + 2);

        // Randomized handshakes against the scoreboard
        base = n_out;
        for (int i = 0; i < N; i++) sent[i] = 0;
        cyc = 0;
        while (n_out - base < 1000 && cyc < 20000) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i] = (sent[i] < 1000) ? 1'($urandom_range(1)) : 1'b0;
                in_data[i*W +: W] = W'($urandom_range(255));
            end
            sum_ready = 1'($urandom_range(1));
            for (int i = 0; i < N; i++) sent[i] += int'(in_valid[i] & rdy0[i]);
            step();
            cyc++;
        end
        in_valid = '0;
        sum_ready = 1;
        step(); step();
        chk("rand_count", n_out - base, 1000);
        for (int i = 0; i < N; i++) chk("rand_leftover", q[i].size(), 0);

        // Mid-stream reset with 5 words queued and 2 sums buffered
        sum_ready = 0;
        for (int c = 0; c < 7; c++) begin
            set_all(4'hf, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
            step();
        end
        in_valid = '0;
        step(); step();
        chk("pre_rst_valid", sv0, 1);
        rst = 1;
        #1;
        chk("rst2_inready", rdy0, 0);
        step();
        chk("rst2_valid", sv0, 0);
        chk("rst2_inready_hi", rdy0, 0);
        rst = 0;
        sum_ready = 1;
        #1;
        chk("rst2_inready_lo", rdy0, 4'hf);
        for (int c = 0; c < 4; c++) step();
        chk("rst2_flushed", sv0, 0);
        set_all(4'hf, 1, 2, 3, 4);
        step();
        in_valid = '0;
        step();
        chk("rst2_first_valid", sv0, 1);
        chk("rst2_first_sum", sd0, 10);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multi_input_sum_using_fifos_and_double_buffer.md
Name: multi_input_sum_using_fifos_and_double_buffer

Overview:
N-channel streaming adder. Each input channel has its own valid/ready FIFO. When every FIFO holds at least one word, the block pops one word from each FIFO in the same cycle. It sums the words at full precision, with an optional saturating mode, and sends the result through a registered 2-entry double buffer to a valid/ready output. It generalises the two-operand FIFO adder to n_inputs channels and adds an overflow flag.

Parameters:
width, 8, bit width of each input operand
depth, 10, entries per input FIFO (>= 2)
n_inputs, 4, number of input channels (>= 2)
saturate, 0, 0 = full-precision sum; 1 = sum clamped to 2**width-1
(derived) sum_width = width + $clog2(n_inputs)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  n_inputs  per-channel valid
in_ready  output  n_inputs  per-channel ready
in_data  input  n_inputs*width  channel i occupies bits [i*width +: width]
sum_valid  output  1  output valid
sum_ready  input  1  output ready
sum_data  output  sum_width  sum of one word from each channel
sum_overflow  output  1  unclamped sum >= 2**width; qualified by sum_valid

Behaviour:
- Reset (rst=1 at clock edge): all FIFOs empty; both double-buffer slots empty; sum_valid=0. sum_data and sum_overflow are don't-care while sum_valid=0 (implementation drives 0).
  - in_ready = 0 while rst is high. Pushes presented during reset are discarded.
  - Reset asserted mid-stream flushes all queued words and buffered sums. No partial sum survives.
- Input side, per channel i:
  - in_ready[i] = ~full[i] (and ~rst). push[i] = in_valid[i] & in_ready[i].
  - There is no bypass when full. A full FIFO keeps in_ready[i]=0 even in a cycle where it pops.
  - FIFO head is first-word-fall-through. A word pushed at edge k is visible at the head after edge k.
  - Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged. Order is strictly FIFO per channel.
- Join:
  - join_valid = AND over i of ~empty[i].
  - pop[i] = join_valid & buf_up_ready for every i simultaneously. A channel is never popped alone.
  - Channels may run at different rates. Words pair by per-channel arrival index, not by time of arrival.
- Arithmetic:
  - raw = sum over i of head[i], zero-extended to sum_width. This never wraps.
  - sum_overflow = (raw >= 2**width).
  - saturate=0: sum_data = raw.
  - saturate=1: sum_data = overflow ? 2**width-1 : raw, zero-extended.
  - The overflow flag is reported in both modes.
- Output double buffer (Dally-Harting style, 2 slots):
  - buf_up_ready is a register, 1 when fewer than 2 slots are occupied.
  - sum_valid, sum_data and sum_overflow come from registers. There is no combinational path from sum_ready or in_* to any output.
  - Transfer occurs when sum_valid & sum_ready. Outputs stay stable while sum_valid=1 and sum_ready=0.
- Latency and throughput:
  - Minimum latency is 2 cycles: last channel pushes at edge k, sum_valid=1 after edge k+1.
  - With sum_ready held high and all channels valid, throughput is 1 sum per cycle.
- Backpressure:
  - With sum_ready=0, the buffer absorbs 2 sums, then buf_up_ready falls and the FIFOs fill.
  - Per-channel storage is depth + 2 words before in_ready[i] drops.
  - When sum_ready rises, draining resumes with no loss or duplication.

Test Plan:
- n_inputs=4, width=8, saturate=0; push 10,20,30,40 on ch0..3 in the same cycle, sum_ready=1 -> sum_valid 2 cycles later, sum_data=100, sum_overflow=0.
- Push 255 on all 4 channels, saturate=0 -> sum_data=1020 (10-bit), sum_overflow=1. Repeat with saturate=1 -> sum_data=255, sum_overflow=1.
- Ch0 pushes 1,2,3 in consecutive cycles; ch1..3 push 0 each five cycles later -> outputs 1,2,3 in that order, no sum_valid before the last channel's first push + 2 cycles.
- sum_ready=0, stream on all channels every cycle -> exactly depth+2 (12) words accepted per channel, then in_ready=0. Raise sum_ready -> 12 correct sums out in order; in_ready returns 1 the cycle after the first pop.
- Random in_valid/sum_ready (50% each), 1000 words per channel vs. scoreboard -> every sum matches, no loss or duplication, sum_data stable while stalled.
- Assert rst for 1 cycle with 5 words queued and 2 sums buffered -> sum_valid=0 and in_ready=0 during reset, all FIFOs empty after it; the first post-reset sum uses only post-reset data.
